out_port_arbiter: RTL and testbench

OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

---
 rtl/out_port_arbiter_if.sv | 21 ++
 rtl/out_port_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_out_port_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/out_port_arbiter_if.sv
// Request/grant/data bundle between three requesters and the output-port arbiter.
// The master side drives requests and data; the slave side returns grant, ack and the pad output.
interface out_port_arbiter_if;
    logic [2:0] REQ;
    logic [3:0] D0;
    logic [3:0] D1;
    logic [3:0] D2;
    logic [2:0] GNT;
    logic [2:0] ACK;
    logic [3:0] O;

    modport master (
        output REQ, D0, D1, D2,
        input  GNT, ACK, O
    );

    modport slave (
        input  REQ, D0, D1, D2,
        output GNT, ACK, O
    );
endinterface

// File: rtl/out_port_arbiter.sv
// Three-requester output-port arbiter: round-robin or fixed-priority grant, per-bit registered/bypass output.
// Optional beat counter is built when OUT_ARB_BEAT_COUNT_EN is defined.
module out_port_arbiter #(
    parameter int NoConfigBits = 6,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                    UserCLK,
    input  logic                    Reset_n,
    input  logic [NoConfigBits-1:0] ConfigBits,
    out_port_arbiter_if.slave       bus
`ifdef OUT_ARB_BEAT_COUNT_EN
    ,
    input  logic                    BeatClr,
    output logic [7:0]              BeatCount
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_gnt;
    logic [3:0] r_dreg;
    logic [3:0] r_cnt;
    logic [1:0] r_last;
    logic [1:0] r_widx;

    logic       w_any;
    logic [1:0] w_win;
    logic [3:0] w_win_data;
    logic [3:0] w_dw;
    logic       w_req_w;
    logic       w_beat_done;
    logic [2:0] w_ack;
    logic [3:0] w_o;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    next_idx = 2'd1;
            2'd1:    next_idx = 2'd2;
            default: next_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] pick_fixed(input logic [2:0] req);
        if (req[0]) begin
            pick_fixed = 2'd0;
        end else if (req[1]) begin
            pick_fixed = 2'd1;
        end else begin
            pick_fixed = 2'd2;
        end
    endfunction

    // Search begins just after the last acknowledged requester and wraps modulo 3.
    function automatic logic [1:0] pick_rr(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        c0 = next_idx(last);
        c1 = next_idx(c0);
        c2 = next_idx(c1);
        if (req[c0]) begin
            pick_rr = c0;
        end else if (req[c1]) begin
            pick_rr = c1;
        end else begin
            pick_rr = c2;
        end
    endfunction

    function automatic logic [3:0] sel_data(input logic [1:0] idx, input logic [3:0] d0,
                                            input logic [3:0] d1, input logic [3:0] d2);
        case (idx)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            default: sel_data = 4'h0;
        endcase
    endfunction

    // Winner selection for the next arbitration; mode bit only matters in IDLE.
    always_comb begin
        w_any = |bus.REQ;
        w_win = 2'd0;
        if (ConfigBits[4]) begin
            w_win = pick_fixed(bus.REQ);
        end else begin
            w_win = pick_rr(bus.REQ, r_last);
        end
        w_win_data = sel_data(w_win, bus.D0, bus.D1, bus.D2);
    end

    // Live data and request level of the currently granted requester.
    always_comb begin
        w_dw    = sel_data(r_widx, bus.D0, bus.D1, bus.D2);
        w_req_w = 1'b0;
        case (r_widx)
            2'd0:    w_req_w = bus.REQ[0];
            2'd1:    w_req_w = bus.REQ[1];
            2'd2:    w_req_w = bus.REQ[2];
            default: w_req_w = 1'b0;
        endcase
    end

    // Next-state, beat-complete and pad output decode.
    always_comb begin
        w_next_state = r_state;
        w_beat_done  = 1'b0;
        w_o          = 4'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_DRIVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
                if (ConfigBits[5]) begin
                    w_o = r_dreg;
                end else begin
                    w_o = 4'h0;
                end
            end
            ST_DRIVE: begin
                // A dropped request aborts the beat even on its final cycle.
                if (!w_req_w) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = ST_IDLE;
                    w_beat_done  = 1'b1;
                end else begin
                    w_next_state = ST_DRIVE;
                end
                for (int i = 0; i < 4; i++) begin
                    if (ConfigBits[i]) begin
                        w_o[i] = r_dreg[i];
                    end else begin
                        w_o[i] = w_dw[i];
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_o          = 4'h0;
            end
        endcase
        w_ack = w_beat_done ? onehot(r_widx) : 3'b000;
    end

    // State register.
    always_ff @(posedge UserCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant, captured data, hold counter and round-robin pointer.
    always_ff @(posedge UserCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_gnt  <= 3'b000;
            r_dreg <= 4'h0;
            r_cnt  <= 4'd0;
            r_last <= 2'd2;
            r_widx <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= onehot(w_win);
                        r_dreg <= w_win_data;
                        r_cnt  <= HOLD_INIT;
                        r_widx <= w_win;
                    end else begin
                        r_gnt <= 3'b000;
                    end
                end
                ST_DRIVE: begin
                    if (w_next_state == ST_IDLE) begin
                        r_gnt <= 3'b000;
                        if (w_beat_done) begin
                            r_last <= r_widx;
                        end else begin
                            r_last <= r_last;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_gnt <= 3'b000;
                end
            endcase
        end
    end

    assign bus.GNT = r_gnt;
    assign bus.ACK = w_ack;
    assign bus.O   = w_o;

`ifdef OUT_ARB_BEAT_COUNT_EN
    logic [7:0] r_beat_count;

    // Saturating count of acknowledged beats; clear has priority.
    always_ff @(posedge UserCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_beat_count <= 8'd0;
        end else if (BeatClr) begin
            r_beat_count <= 8'd0;
        end else if (w_beat_done && (r_beat_count != 8'hFF)) begin
            r_beat_count <= r_beat_count + 8'd1;
        end else begin
            r_beat_count <= r_beat_count;
        end
    end

    assign BeatCount = r_beat_count;
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed self-checking bench for out_port_arbiter (HOLD_CYCLES = 2, 3-cycle beat period).
module tb_out_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [5:0] cfg;
    int         total;
    int         bad;

    out_port_arbiter_if bus_if ();

`ifdef OUT_ARB_BEAT_COUNT_EN
    logic       beat_clr;
    logic [7:0] beat_count;
`endif

    out_port_arbiter #(
        .NoConfigBits(6),
        .HOLD_CYCLES (2)
    ) dut (
        .UserCLK   (clk),
        .Reset_n   (rst_n),
        .ConfigBits(cfg),
        .bus       (bus_if)
`ifdef OUT_ARB_BEAT_COUNT_EN
        ,
        .BeatClr   (beat_clr),
        .BeatCount (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        bus_if.REQ = 3'b000;
        rst_n      = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cfg       = 6'h00;
        bus_if.D0 = 4'h0;
        bus_if.D1 = 4'h0;
        bus_if.D2 = 4'h0;
        apply_reset();
        #1;
        total++; if (bus_if.GNT !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b want=000", bus_if.GNT); end
        total++; if (bus_if.ACK !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b want=000", bus_if.ACK); end
        total++; if (bus_if.O !== 4'h0) begin bad++; $display("FAIL reset_o got=%h want=0", bus_if.O); end
    endtask

    task automatic test_single_beat();
        apply_reset();
        cfg        = 6'h0F;
        bus_if.D0  = 4'hA;
        bus_if.REQ = 3'b001;
        step(); #1;
        total++; if (bus_if.GNT !== 3'b001) begin bad++; $display("FAIL single_gnt got=%b want=001", bus_if.GNT); end
        total++; if (bus_if.O !== 4'hA) begin bad++; $display("FAIL single_o1 got=%h want=a", bus_if.O); end
        total++; if (bus_if.ACK !== 3'b000) begin bad++; $display("FAIL single_noack got=%b want=000", bus_if.ACK); end
        step(); #1;
        total++; if (bus_if.O !== 4'hA) begin bad++; $display("FAIL single_o2 got=%h want=a", bus_if.O); end
        total++; if (bus_if.ACK !== 3'b001) begin bad++; $display("FAIL single_ack got=%b want=001", bus_if.ACK); end
        bus_if.REQ = 3'b000;
        step(); #1;
        total++; if (bus_if.GNT !== 3'b000) begin bad++; $display("FAIL single_idle_gnt got=%b want=000", bus_if.GNT); end
        total++; if (bus_if.O !== 4'h0) begin bad++; $display("FAIL single_idle_o got=%h want=0", bus_if.O); end
        total++; if (bus_if.ACK !== 3'b000) begin bad++; $display("FAIL single_idle_ack got=%b want=000", bus_if.ACK); end
    endtask

    task automatic test_round_robin();
        logic [2:0] order [4];
        logic [3:0] data  [4];
        logic [2:0] exp_g;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        data[0]  = 4'h1;   data[1]  = 4'h2;   data[2]  = 4'h3;   data[3]  = 4'h1;
        apply_reset();
        cfg        = 6'h0F;
        bus_if.D0  = 4'h1;
        bus_if.D1  = 4'h2;
        bus_if.D2  = 4'h3;
        bus_if.REQ = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            step(); #1;
            exp_g = ((k % 3) == 0) ? 3'b000 : order[(k - 1) / 3];
            total++; if (bus_if.GNT !== exp_g) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", k, bus_if.GNT, exp_g); end
            if ((k % 3) == 2) begin
                total++; if (bus_if.ACK !== exp_g) begin bad++; $display("FAIL rr_ack cyc=%0d got=%b want=%b", k, bus_if.ACK, exp_g); end
                total++; if (bus_if.O !== data[(k - 1) / 3]) begin bad++; $display("FAIL rr_o cyc=%0d got=%h want=%h", k, bus_if.O, data[(k - 1) / 3]); end
            end
        end
        bus_if.REQ = 3'b000;
        step();
    endtask

    task automatic test_fixed_priority();
        logic [2:0] exp_g;
        apply_reset();
        cfg        = 6'h1F;
        bus_if.REQ = 3'b110;
        for (int k = 1; k <= 9; k++) begin
            step(); #1;
            exp_g = ((k % 3) == 0) ? 3'b000 : 3'b010;
            total++; if (bus_if.GNT !== exp_g) begin bad++; $display("FAIL fixed_gnt cyc=%0d got=%b want=%b", k, bus_if.GNT, exp_g); end
        end
        bus_if.REQ = 3'b000;
        step();
    endtask

    task automatic test_bypass();
        apply_reset();
        cfg        = 6'h05;
        bus_if.D1  = 4'h0;
        bus_if.REQ = 3'b010;
        step(); #1;
        total++; if (bus_if.GNT !== 3'b010) begin bad++; $display("FAIL bypass_gnt got=%b want=010", bus_if.GNT); end
        total++; if (bus_if.O !== 4'h0) begin bad++; $display("FAIL bypass_o_before got=%h want=0", bus_if.O); end
        bus_if.D1 = 4'hF;
        #1;
        total++; if (bus_if.O !== 4'hA) begin bad++; $display("FAIL bypass_o_live got=%h want=a", bus_if.O); end
        step(); #1;
        total++; if (bus_if.ACK !== 3'b010) begin bad++; $display("FAIL bypass_ack got=%b want=010", bus_if.ACK); end
        bus_if.REQ = 3'b000;
        step();
    endtask

    task automatic test_abort();
        apply_reset();
        cfg        = 6'h2F;
        bus_if.D0  = 4'h6;
        bus_if.REQ = 3'b001;
        step();
        bus_if.REQ = 3'b000;
        #1;
        total++; if (bus_if.ACK !== 3'b000) begin bad++; $display("FAIL abort_ack got=%b want=000", bus_if.ACK); end
        step(); #1;
        total++; if (bus_if.GNT !== 3'b000) begin bad++; $display("FAIL abort_gnt got=%b want=000", bus_if.GNT); end
        total++; if (bus_if.O !== 4'h6) begin bad++; $display("FAIL abort_park got=%h want=6", bus_if.O); end
        bus_if.REQ = 3'b111;
        step(); #1;
        total++; if (bus_if.GNT !== 3'b001) begin bad++; $display("FAIL abort_rr_keep got=%b want=001", bus_if.GNT); end
        step();
        bus_if.REQ = 3'b110;
        #1;
        total++; if (bus_if.ACK !== 3'b000) begin bad++; $display("FAIL abort_last_ack got=%b want=000", bus_if.ACK); end
        step(); #1;
        total++; if (bus_if.GNT !== 3'b000) begin bad++; $display("FAIL abort_last_gnt got=%b want=000", bus_if.GNT); end
        bus_if.REQ = 3'b000;
        step();
    endtask

    task automatic test_reset_mid_beat();
        apply_reset();
        cfg        = 6'h2F;
        bus_if.D0  = 4'h5;
        bus_if.REQ = 3'b001;
        step(); #1;
        total++; if (bus_if.GNT !== 3'b001) begin bad++; $display("FAIL midrst_pre_gnt got=%b want=001", bus_if.GNT); end
        step();
        rst_n = 1'b0;
        #1;
        total++; if (bus_if.GNT !== 3'b000) begin bad++; $display("FAIL midrst_gnt got=%b want=000", bus_if.GNT); end
        total++; if (bus_if.ACK !== 3'b000) begin bad++; $display("FAIL midrst_ack got=%b want=000", bus_if.ACK); end
        total++; if (bus_if.O !== 4'h0) begin bad++; $display("FAIL midrst_o got=%h want=0", bus_if.O); end
        step();
        rst_n = 1'b1;
        step(); #1;
        total++; if (bus_if.GNT !== 3'b001) begin bad++; $display("FAIL midrst_regrant got=%b want=001", bus_if.GNT); end
        bus_if.REQ = 3'b000;
        step();
        step();
    endtask

`ifdef OUT_ARB_BEAT_COUNT_EN
    task automatic test_beat_count();
        beat_clr = 1'b0;
        apply_reset();
        #1;
        total++; if (beat_count !== 8'd0) begin bad++; $display("FAIL bc_reset got=%0d want=0", beat_count); end
        cfg        = 6'h0F;
        bus_if.REQ = 3'b111;
        for (int k = 0; k < 30; k++) step();
        #1;
        total++; if (beat_count !== 8'd10) begin bad++; $display("FAIL bc_ten got=%0d want=10", beat_count); end
        for (int k = 0; k < 870; k++) step();
        #1;
        total++; if (beat_count !== 8'd255) begin bad++; $display("FAIL bc_sat got=%0d want=255", beat_count); end
        beat_clr = 1'b1;
        step();
        beat_clr = 1'b0;
        #1;
        total++; if (beat_count !== 8'd0) begin bad++; $display("FAIL bc_clr got=%0d want=0", beat_count); end
        bus_if.REQ = 3'b000;
        step();
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        cfg        = 6'h00;
        bus_if.REQ = 3'b000;
        bus_if.D0  = 4'h0;
        bus_if.D1  = 4'h0;
        bus_if.D2  = 4'h0;
`ifdef OUT_ARB_BEAT_COUNT_EN
        beat_clr = 1'b0;
`endif
        #3;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_fixed_priority();
        test_bypass();
        test_abort();
        test_reset_mid_beat();
`ifdef OUT_ARB_BEAT_COUNT_EN
        test_beat_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
